// File: rtl/vlsu_axi_mem_responder.sv
// AXI4 subordinate memory responder sitting at the far end of the VLSU AXI
// master port. It serves exactly one burst at a time out of a single-port,
// byte-enabled storage array. Reads return the full bus word that contains
// each beat address. Writes update only the byte lanes whose strobe is set.
//
// Handshake rule on every channel: a transfer happens on a rising clk_i edge
// where both valid and ready are high. A valid driven by this block stays
// high, with its payload held stable, until that transfer takes place.
module vlsu_axi_mem_responder #(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned MemBytes     = 65536
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // read address channel
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [AxiIdWidth-1:0]     ar_id_i,
    input  logic [AxiAddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]                ar_len_i,
    input  logic [2:0]                ar_size_i,
    input  logic [1:0]                ar_burst_i,
    // read data channel
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic [AxiIdWidth-1:0]     r_id_o,
    output logic [AxiDataWidth-1:0]   r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      r_last_o,
    // write address channel
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AxiIdWidth-1:0]     aw_id_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    // write data channel
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    // write response channel
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic [AxiIdWidth-1:0]     b_id_o,
    output logic [1:0]                b_resp_o,
    // FSM state for observation (0 idle, 1 read, 2 write data, 3 write resp)
    output logic [1:0]                dbg_state_o
);

    localparam int unsigned StrbW = AxiDataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned MemAw = $clog2(MemBytes);
    localparam int unsigned Words = MemBytes / StrbW;
    localparam logic [2:0]  MaxSize = 3'(OffW);
    localparam logic [1:0]  BurstIncr = 2'b01;
    localparam logic [1:0]  RespOkay  = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_DATA  = 2'd2,
        WR_RESP  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   prio_q, prio_d;   // 0: read wins a tie, 1: write wins a tie

    // burst context shared by reads and writes, only one is ever in service
    logic [AxiIdWidth-1:0]   id_q;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [7:0]              len_q;
    logic [2:0]              size_q;
    logic                    err_q;
    logic [8:0]              cnt_q;

    logic [AxiDataWidth-1:0] r_data_q;
    logic                    r_last_q;
    logic [1:0]              b_resp_q;

    logic [AxiDataWidth-1:0] mem_q [Words];

    logic                    ar_grant, aw_grant;
    logic                    r_hs, w_hs, b_hs;
    logic                    ar_err, aw_err;
    logic [AxiAddrWidth-1:0] nxt_addr;
    logic [MemAw-OffW-1:0]   rd_idx, wr_idx;
    logic [AxiDataWidth-1:0] rd_word;
    logic                    last_rd_beat;
    logic [8:0]              cnt_inc;

    // Address of the following beat: align down to the beat size, then step.
    function automatic logic [AxiAddrWidth-1:0] next_beat(
        input logic [AxiAddrWidth-1:0] a,
        input logic [2:0]              sz
    );
        logic [AxiAddrWidth-1:0] step;
        step = {{(AxiAddrWidth-1){1'b0}}, 1'b1} << sz;
        return (a & ~(step - 1'b1)) + step;
    endfunction

    // State register and arbitration priority
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Next-state logic; priority toggles on every address grant
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q ^ (ar_grant | aw_grant);
        unique case (state_q)
            IDLE: begin
                if (ar_grant)      state_d = RD_BURST;
                else if (aw_grant) state_d = WR_DATA;
            end
            RD_BURST: if (r_hs && r_last_q) state_d = IDLE;
            WR_DATA:  if (w_hs && w_last_i) state_d = WR_RESP;
            WR_RESP:  if (b_hs)             state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode: readies, valids and the grant decision
    always_comb begin
        ar_grant    = (state_q == IDLE) && ar_valid_i && (!aw_valid_i || !prio_q);
        aw_grant    = (state_q == IDLE) && aw_valid_i && (!ar_valid_i ||  prio_q);
        ar_ready_o  = ar_grant;
        aw_ready_o  = aw_grant;
        r_valid_o   = (state_q == RD_BURST);
        w_ready_o   = (state_q == WR_DATA);
        b_valid_o   = (state_q == WR_RESP);
        r_hs        = r_valid_o && r_ready_i;
        w_hs        = w_valid_i && w_ready_o;
        b_hs        = b_valid_o && b_ready_i;
        dbg_state_o = state_q;
    end

    // Burst legality, beat address stepping and storage read port
    always_comb begin
        ar_err       = (ar_burst_i != BurstIncr) || (ar_size_i > MaxSize);
        aw_err       = (aw_burst_i != BurstIncr) || (aw_size_i > MaxSize);
        nxt_addr     = next_beat(addr_q, size_q);
        rd_idx       = (state_q == IDLE) ? ar_addr_i[MemAw-1:OffW] : nxt_addr[MemAw-1:OffW];
        wr_idx       = addr_q[MemAw-1:OffW];
        rd_word      = mem_q[rd_idx];
        cnt_inc      = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
        last_rd_beat = (cnt_inc == {1'b0, len_q});
    end

    // Burst context capture, beat sequencing and registered R/B payloads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            r_data_q <= '0;
            r_last_q <= 1'b0;
            b_resp_q <= RespOkay;
        end else if (ar_grant) begin
            id_q     <= ar_id_i;
            addr_q   <= ar_addr_i;
            len_q    <= ar_len_i;
            size_q   <= ar_size_i;
            err_q    <= ar_err;
            cnt_q    <= '0;
            r_data_q <= ar_err ? '0 : rd_word;
            r_last_q <= (ar_len_i == 8'd0);
        end else if (aw_grant) begin
            id_q     <= aw_id_i;
            addr_q   <= aw_addr_i;
            len_q    <= aw_len_i;
            size_q   <= aw_size_i;
            err_q    <= aw_err;
            cnt_q    <= '0;
        end else if (r_hs) begin
            // the next beat is presented on the same edge that retires this one
            if (!r_last_q) begin
                addr_q   <= nxt_addr;
                cnt_q    <= cnt_inc;
                r_data_q <= err_q ? '0 : rd_word;
                r_last_q <= last_rd_beat;
            end else begin
                r_last_q <= 1'b0;
            end
        end else if (w_hs) begin
            addr_q <= nxt_addr;
            cnt_q  <= cnt_inc;   // saturates so a runaway burst can never alias to len
            if (w_last_i) begin
                b_resp_q <= (err_q || (cnt_q != {1'b0, len_q})) ? RespSlvErr : RespOkay;
            end
        end
    end

    // Storage write port: strobed lanes of the bus word holding the beat
    // address, only for legal bursts and only for beats within len+1
    always_ff @(posedge clk_i) begin
        if (w_hs && !err_q && (cnt_q <= {1'b0, len_q})) begin
            for (int j = 0; j < StrbW; j++) begin
                if (w_strb_i[j]) mem_q[wr_idx][8*j +: 8] <= w_data_i[8*j +: 8];
            end
        end
    end

    assign r_id_o   = id_q;
    assign r_data_o = r_data_q;
    assign r_resp_o = err_q ? RespSlvErr : RespOkay;
    assign r_last_o = r_last_q;
    assign b_id_o   = id_q;
    assign b_resp_o = b_resp_q;

endmodule

// File: tb/tb_vlsu_axi_mem_responder.sv
// Bench for vlsu_axi_mem_responder: directed bursts plus randomized traffic,
// checked against a byte-array model of the storage.
module tb_vlsu_axi_mem_responder;

    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int IW  = 4;
    localparam int MB  = 65536;
    localparam int BPB = DW / 8;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            ar_valid, ar_ready;
    logic [IW-1:0]   ar_id;
    logic [AW-1:0]   ar_addr;
    logic [7:0]      ar_len;
    logic [2:0]      ar_size;
    logic [1:0]      ar_burst;
    logic            r_valid, r_ready;
    logic [IW-1:0]   r_id;
    logic [DW-1:0]   r_data;
    logic [1:0]      r_resp;
    logic            r_last;
    logic            aw_valid, aw_ready;
    logic [IW-1:0]   aw_id;
    logic [AW-1:0]   aw_addr;
    logic [7:0]      aw_len;
    logic [2:0]      aw_size;
    logic [1:0]      aw_burst;
    logic            w_valid, w_ready;
    logic [DW-1:0]   w_data;
    logic [BPB-1:0]  w_strb;
    logic            w_last;
    logic            b_valid, b_ready;
    logic [IW-1:0]   b_id;
    logic [1:0]      b_resp;
    logic [1:0]      dbg_state;

    logic [7:0] ref_mem [MB];
    int n_checks = 0;
    int n_fail   = 0;

    // clock
    always #5 clk = ~clk;

    vlsu_axi_mem_responder dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len), .ar_size_i(ar_size), .ar_burst_i(ar_burst),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
        .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] beat_step(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] bytes;
        bytes = 32'd1 << sz;
        return (a & ~(bytes - 32'd1)) + bytes;
    endfunction

    function automatic logic [127:0] model_word(input logic [31:0] a);
        logic [127:0] w;
        logic [31:0]  base;
        base = a & ~32'(BPB - 1);
        for (int j = 0; j < BPB; j++) w[8*j +: 8] = ref_mem[(base + 32'(j)) % MB];
        return w;
    endfunction

    function automatic bit is_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst != 2'b01) || ((32'd1 << size) > BPB);
    endfunction

    // ---------------- driver tasks (enter/leave at posedge + 1) ----------------
    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cyc = 0;
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        @(negedge clk);
        while (!ar_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!ar_ready) check("ar_ready_timeout", ar_ready, 1'b1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int cyc = 0;
        aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        @(negedge clk);
        while (!aw_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!aw_ready) check("aw_ready_timeout", aw_ready, 1'b1);
        @(posedge clk); #1;
        aw_valid = 1'b0;
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_beat, input int stall_cyc, input bit rnd_ready);
        logic [127:0] exp_q[$];
        logic [31:0]  a;
        bit           err;
        int           beat = 0, cyc = 0, stall_left;
        err = is_err(burst, size);
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            exp_q.push_back(model_word(a));
            a = beat_step(a, size);
        end
        stall_left = stall_cyc;
        send_ar(id, addr, len, size, burst);
        while (beat <= int'(len) && cyc < 3000) begin
            if (beat == stall_beat && stall_left > 0) begin
                r_ready = 1'b0;
                stall_left--;
            end else if (rnd_ready) r_ready = ($urandom_range(0, 2) != 0);
            else r_ready = 1'b1;
            @(negedge clk);
            check("r_valid", r_valid, 1'b1);
            if (!r_valid) break;
            if (!err) check("r_data", r_data, exp_q[beat]);
            check("r_last", r_last, (beat == int'(len)));
            check("r_resp", r_resp, err ? 2'b10 : 2'b00);
            check("r_id", r_id, id);
            if (r_ready) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        r_ready = 1'b0;
        @(negedge clk);
        check("r_valid_after_last", r_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input bit use_fixed, input logic [15:0] fixed_strb,
                            input bit seq_data, input bit gaps);
        logic [31:0] a, base;
        bit          err;
        logic [1:0]  exp_resp;
        int          cyc, hold;
        err = is_err(burst, size);
        exp_resp = (err || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
        a = addr;
        send_aw(id, addr, len, size, burst);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                w_valid = 1'b0;
                @(posedge clk); #1;
            end
            w_valid = 1'b1;
            if (seq_data) for (int k = 0; k < BPB; k++) w_data[8*k +: 8] = 8'(i * BPB + k);
            else w_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            w_strb = use_fixed ? fixed_strb : 16'($urandom_range(0, 65535));
            w_last = (i == nbeats - 1);
            cyc = 0;
            @(negedge clk);
            while (!w_ready && cyc < 50) begin @(negedge clk); cyc++; end
            if (!w_ready) check("w_ready_timeout", w_ready, 1'b1);
            if (!err && i <= int'(len)) begin
                base = a & ~32'(BPB - 1);
                for (int j = 0; j < BPB; j++)
                    if (w_strb[j]) ref_mem[(base + 32'(j)) % MB] = w_data[8*j +: 8];
            end
            a = beat_step(a, size);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!b_valid && cyc < 50) begin @(negedge clk); cyc++; end
        check("b_valid", b_valid, 1'b1);
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("b_valid_hold", b_valid, 1'b1);
        end
        check("b_id", b_id, id);
        check("b_resp", b_resp, exp_resp);
        @(posedge clk); #1;
        b_ready = 1'b1;
        @(negedge clk);
        check("b_valid_at_ready", b_valid, 1'b1);
        @(posedge clk); #1;
        b_ready = 1'b0;
        @(negedge clk);
        check("b_valid_after", b_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]  rid;
        logic [7:0]  rlen;
        logic [2:0]  rsize;
        logic [1:0]  rburst;
        logic [31:0] raddr;
        int          nb;

        rst_ni = 1'b0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
        r_ready = 0; b_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ar_ready", ar_ready, 1'b0);
        check("rst_aw_ready", aw_ready, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_w_ready", w_ready, 1'b0);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_r_payload", {r_id, r_data, r_resp, r_last}, '0);
        check("rst_b_payload", {b_id, b_resp}, '0);
        check("rst_state", dbg_state, 2'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // fill the low 4 KB with random data in one 256-beat burst
        wr_burst(4'h0, 32'h0, 8'd255, 3'd4, 2'b01, 256, 1'b1, 16'hFFFF, 1'b0, 1'b0);

        // bytes 0..63 at 0x100, then a back-to-back read of them
        wr_burst(4'h1, 32'h100, 8'd3, 3'd4, 2'b01, 4, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        rd_burst(4'h1, 32'h100, 8'd3, 3'd4, 2'b01, -1, 0, 1'b0);

        // sub-word strobe write at an unaligned address
        wr_burst(4'h9, 32'h203, 8'd0, 3'd4, 2'b01, 1, 1'b1, 16'h00F0, 1'b0, 1'b0);
        rd_burst(4'h2, 32'h200, 8'd0, 3'd4, 2'b01, -1, 0, 1'b0);

        // 5-cycle stall on beat 1
        rd_burst(4'h3, 32'h100, 8'd3, 3'd4, 2'b01, 1, 5, 1'b0);

        // early w_last, then extra beats past len
        wr_burst(4'h4, 32'h400, 8'd3, 3'd4, 2'b01, 3, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        wr_burst(4'h5, 32'h500, 8'd1, 3'd4, 2'b01, 4, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        rd_burst(4'h5, 32'h500, 8'd3, 3'd4, 2'b01, -1, 0, 1'b0);

        // WRAP burst returns SLVERR on both beats
        rd_burst(4'h6, 32'h600, 8'd1, 3'd4, 2'b10, -1, 0, 1'b0);

        // reset in the middle of a read
        send_ar(4'h7, 32'h0, 8'd15, 3'd4, 2'b01);
        r_ready = 1'b1;
        @(negedge clk);
        check("mid_r_valid", r_valid, 1'b1);
        @(posedge clk); #1;
        r_ready = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_r_valid", r_valid, 1'b0);
        check("mid_rst_r_last", r_last, 1'b0);
        check("mid_rst_r_data", r_data, '0);
        check("mid_rst_state", dbg_state, 2'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        r_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_r_after_rst", r_valid, 1'b0);
            @(posedge clk); #1;
        end
        r_ready = 1'b0;

        // arbitration: first tie after reset goes to AR, the next tie to AW
        ar_valid = 1'b1; ar_id = 4'h1; ar_addr = 32'h100; ar_len = 8'd0; ar_size = 3'd4; ar_burst = 2'b01;
        aw_valid = 1'b1; aw_id = 4'h2; aw_addr = 32'h300; aw_len = 8'd0; aw_size = 3'd4; aw_burst = 2'b01;
        @(negedge clk);
        check("tie1_ar_ready", ar_ready, 1'b1);
        check("tie1_aw_ready", aw_ready, 1'b0);
        @(posedge clk); #1;
        ar_id = 4'h3; ar_addr = 32'h300;
        r_ready = 1'b1;
        @(negedge clk);
        check("tie1_r_data", r_data, model_word(32'h100));
        check("tie1_r_last", r_last, 1'b1);
        @(posedge clk); #1;
        r_ready = 1'b0;
        @(negedge clk);
        check("tie2_aw_ready", aw_ready, 1'b1);
        check("tie2_ar_ready", ar_ready, 1'b0);
        @(posedge clk); #1;
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        w_strb = 16'hFFFF; w_last = 1'b1;
        for (int j = 0; j < BPB; j++) ref_mem[32'h300 + j] = w_data[8*j +: 8];
        @(negedge clk);
        check("tie2_w_ready", w_ready, 1'b1);
        @(posedge clk); #1;
        w_valid = 1'b0; w_last = 1'b0;
        b_ready = 1'b1;
        @(negedge clk);
        check("tie2_b_valid", b_valid, 1'b1);
        check("tie2_b_id", b_id, 4'h2);
        check("tie2_b_resp", b_resp, 2'b00);
        check("tie2_ar_blocked", ar_ready, 1'b0);
        @(posedge clk); #1;
        b_ready = 1'b0;
        @(negedge clk);
        check("tie3_ar_ready", ar_ready, 1'b1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        check("tie3_r_valid", r_valid, 1'b1);
        check("tie3_r_id", r_id, 4'h3);
        check("tie3_r_data", r_data, model_word(32'h300));
        @(posedge clk); #1;
        r_ready = 1'b0;

        // randomized mixed traffic
        for (int t = 0; t < 40; t++) begin
            rid    = 4'($urandom_range(0, 15));
            rlen   = 8'($urandom_range(0, 7));
            rsize  = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) rsize = 3'd5;
            rburst = 2'b01;
            if ($urandom_range(0, 9) == 0) rburst = 2'($urandom_range(0, 2));
            raddr  = 32'($urandom_range(0, 32'hBFF));
            if ($urandom_range(0, 1) == 1) begin
                nb = int'(rlen) + 1;
                if ($urandom_range(0, 5) == 0) nb = nb + $urandom_range(1, 2);
                else if (rlen > 0 && $urandom_range(0, 5) == 0) nb = nb - 1;
                wr_burst(rid, raddr, rlen, rsize, rburst, nb, 1'b0, 16'h0, 1'b0, 1'b1);
            end else begin
                rd_burst(rid, raddr, rlen, rsize, rburst, -1, 0, 1'b1);
            end
        end

        // sweep the filled region
        for (int s = 0; s < 4; s++)
            rd_burst(4'(s), 32'(s * 256), 8'd15, 3'd4, 2'b01, -1, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
